// File: rtl/mem_arbiter.sv
// Round-robin line-fill arbiter: instruction and data cache controllers share one memory port.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int OFFS_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              err,
  output logic [2:0]        fsm_state,
  output logic              last_grant
);

  // Handshake: x_req is a level held until the requester sees x_ready (a one-cycle
  // pulse); mem_req is held with stable mem_* until a one-cycle mem_ack.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MEM_I  = 3'd1,
    MEM_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

  state_t state;
  logic   d_we_q;
  logic   grant_d;
  logic   grant_i;
  logic   in_mem;
  logic   timeout_hit;

  assign fsm_state = state;
  assign in_mem    = (state == MEM_I) || (state == MEM_D);

  // last_grant: 0 = instruction, 1 = data; on contention the other port wins.
  assign grant_d = d_req && (!i_req || !last_grant);
  assign grant_i = i_req && !grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;

  assign timeout_hit = (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (in_mem && !mem_ack && !timeout_hit) wd <= wd + 1'b1;
      else                                    wd <= '0;
      if (in_mem && !mem_ack && timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      d_we_q     <= 1'b0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req    <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr & ALIGN_MASK;
            mem_wdata  <= d_wdata;
            d_we_q     <= d_we;
            last_grant <= 1'b1;
            state      <= MEM_D;
          end else if (grant_i) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr & ALIGN_MASK;
            mem_wdata  <= '0;
            last_grant <= 1'b0;
            state      <= MEM_I;
          end
        end
        MEM_I: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            i_rdata <= mem_rdata;
            i_ready <= 1'b1;
            state   <= RESP_I;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            i_rdata <= '0;
            i_ready <= 1'b1;
            state   <= RESP_I;
          end
        end
        MEM_D: begin
          // Write-backs return no line, so d_rdata keeps its previous fill.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!d_we_q) d_rdata <= mem_rdata;
            d_ready <= 1'b1;
            state   <= RESP_D;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            d_rdata <= '0;
            d_ready <= 1'b1;
            state   <= RESP_D;
          end
        end
        RESP_I:  state <= IDLE;
        RESP_D:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout scenario selected by MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_ready;
  logic [127:0] i_rdata;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [127:0] d_wdata;
  logic         d_ready;
  logic [127:0] d_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic         err;
  logic [2:0]   fsm_state;
  logic         last_grant;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_MEM_I = 3'd1, S_MEM_D = 3'd2,
                         S_RESP_I = 3'd3, S_RESP_D = 3'd4;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .OFFS_W(4), .TIMEOUT(8)) dut (
    .clock(clk), .reset(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .fsm_state(fsm_state), .last_grant(last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_mem_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, mem_req, 1);
  endtask

  // Entered in the first MEM cycle; returns in the RESP cycle.
  task automatic mem_ack_after(input int lat, input logic [127:0] rd);
    if (lat > 1) cyc(lat - 1);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] line_a, line_d1, line_i1, wline, last_d;
    int n;
    line_a  = {4{32'hAAAA_AAAA}};
    line_d1 = {4{32'hD1D1_0001}};
    line_i1 = {4{32'h1111_0101}};
    wline   = {8{16'h1122}};
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0; rst_n = 1'b0;

    // Reset with clock running
    cyc(3);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_state", fsm_state, S_IDLE);
    chk("rst_last_grant", last_grant, 0);
    rst_n = 1'b1;

    // Single instruction fill, ack after 3 cycles
    i_req = 1; i_addr = 32'h0000_1234;
    cyc();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h0000_1230);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_state", fsm_state, S_MEM_I);
    mem_ack_after(3, line_a);
    i_req = 0;
    chk("t1_i_ready", i_ready, 1);
    chk("t1_i_rdata", i_rdata, line_a);
    chk("t1_mem_req_drop", mem_req, 0);
    chk("t1_d_ready", d_ready, 0);
    cyc();
    chk("t1_i_ready_pulse", i_ready, 0);
    chk("t1_i_rdata_hold", i_rdata, line_a);
    chk("t1_idle", fsm_state, S_IDLE);

    // Simultaneous requests right after reset: D first, then I
    do_reset();
    i_req = 1; i_addr = 32'h0000_0040;
    d_req = 1; d_addr = 32'h0000_0100; d_we = 0; d_wdata = '0;
    cyc();
    chk("t2_first_addr", mem_addr, 32'h0000_0100);
    chk("t2_first_state", fsm_state, S_MEM_D);
    chk("t2_lg_d", last_grant, 1);
    mem_ack_after(1, line_d1);
    d_req = 0;
    chk("t2_d_ready", d_ready, 1);
    chk("t2_i_ready_quiet", i_ready, 0);
    chk("t2_d_rdata", d_rdata, line_d1);
    cyc();
    chk("t2_idle", fsm_state, S_IDLE);
    cyc();
    chk("t2_second_state", fsm_state, S_MEM_I);
    chk("t2_second_addr", mem_addr, 32'h0000_0040);
    chk("t2_lg_i", last_grant, 0);
    mem_ack_after(1, line_i1);
    i_req = 0;
    chk("t2_i_ready", i_ready, 1);
    chk("t2_i_rdata", i_rdata, line_i1);
    chk("t2_d_rdata_kept", d_rdata, line_d1);
    cyc();

    // Continuous contention: D, I, D, I
    i_req = 1; i_addr = 32'h0000_2007;
    d_req = 1; d_addr = 32'h0000_030C; d_we = 0;
    last_d = line_d1;
    for (int k = 0; k < 4; k++) begin
      logic is_d;
      logic [127:0] data;
      is_d = (k % 2 == 0);
      data = {4{32'hC0DE_0000 + 32'(k)}};
      wait_mem_req($sformatf("t3_req_%0d", k));
      chk($sformatf("t3_addr_%0d", k), mem_addr, is_d ? 32'h0000_0300 : 32'h0000_2000);
      chk($sformatf("t3_lg_%0d", k), last_grant, is_d);
      mem_ack_after(1 + k, data);
      chk($sformatf("t3_d_ready_%0d", k), d_ready, is_d);
      chk($sformatf("t3_i_ready_%0d", k), i_ready, !is_d);
      if (is_d) last_d = data;
      chk($sformatf("t3_d_rdata_%0d", k), d_rdata, last_d);
      if (k == 3) begin
        i_req = 0;
        d_req = 0;
      end
      cyc();
    end
    chk("t3_i_rdata_final", i_rdata, {4{32'hC0DE_0003}});

    // Data write-back leaves d_rdata untouched
    d_req = 1; d_we = 1; d_addr = 32'h0000_2008; d_wdata = wline;
    cyc();
    chk("t4_mem_we", mem_we, 1);
    chk("t4_mem_addr", mem_addr, 32'h0000_2000);
    chk("t4_mem_wdata", mem_wdata, wline);
    mem_ack_after(2, {4{32'hFFFF_FFFF}});
    d_req = 0; d_we = 0;
    chk("t4_d_ready", d_ready, 1);
    chk("t4_d_rdata_kept", d_rdata, last_d);
    cyc();

    // Asynchronous reset during MEM_D abandons the transaction
    d_req = 1; d_addr = 32'h0000_0400;
    cyc();
    chk("t5_mem_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_mem_req", mem_req, 0);
    chk("t5_async_state", fsm_state, S_IDLE);
    d_req = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    mem_ack = 1; mem_rdata = line_a;
    cyc();
    mem_ack = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_no_d_ready_%0d", k), d_ready, 0);
      chk($sformatf("t5_idle_%0d", k), fsm_state, S_IDLE);
      cyc();
    end
    chk("t5_d_rdata_cleared", d_rdata, 0);

    // Memory never acknowledges
    i_req = 1; i_addr = 32'h0000_0500;
    cyc();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      cyc();
    end
`ifdef MEM_ARB_TIMEOUT_EN
    chk("t6_req_cycles", n, 8);
    chk("t6_i_ready", i_ready, 1);
    chk("t6_i_rdata_zero", i_rdata, 0);
    chk("t6_err", err, 1);
    i_req = 0;
    cyc();
    mem_ack = 1; mem_rdata = line_a;
    cyc();
    mem_ack = 0;
    cyc(2);
    chk("t6_late_ack_state", fsm_state, S_IDLE);
    chk("t6_late_ack_i_ready", i_ready, 0);
    chk("t6_late_ack_i_rdata", i_rdata, 0);
    chk("t6_err_sticky", err, 1);
`else
    chk("t6_req_held", n, 20);
    chk("t6_err_zero", err, 0);
    chk("t6_still_mem_i", fsm_state, S_MEM_I);
    i_req = 0;
`endif
    do_reset();
    chk("t6_err_after_reset", err, 0);
    chk("t6_state_after_reset", fsm_state, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
